// File: rtl/rvfi_mon_pkg.sv
// Shared types and helpers for the RVFI commit serializer.
// rvfi_pkt_t     : one retired instruction in RVFI field layout.
// popcount_contig: number of contiguous valid lanes counted up from lane 0.
package rvfi_mon_pkg;

  localparam int unsigned MAX_LANES  = 8;
  localparam int unsigned LANE_CNT_W = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic        trap;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        load_regfile;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  localparam int unsigned PKT_W = $bits(rvfi_pkt_t);

  // Lanes past the first invalid one do not count, even if they are set.
  function automatic logic [LANE_CNT_W-1:0] popcount_contig(input logic [MAX_LANES-1:0] valid);
    logic [LANE_CNT_W-1:0] n;
    logic                  run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      run = run & valid[i];
      if (run) n = n + LANE_CNT_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/multi_push_fifo.sv
// N-write / 1-read circular buffer.
// clk, rst   : clock, async active-high reset (empties the buffer)
// push_n     : number of entries written this cycle, taken from push_data lanes 0..push_n-1
// push_data  : per-lane write data, lane 0 lands at the tail
// pop        : remove the head entry (caller guarantees non-empty)
// head       : current head entry
// count      : number of occupied entries
module multi_push_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NPUSH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned PN_W  = $clog2(NPUSH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PN_W-1:0]             push_n,
  input  logic [NPUSH-1:0][WIDTH-1:0] push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [CNT_W-1:0]            count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPUSH; k++) begin
      if (PN_W'(k) < push_n) mem[wr_ptr + PTR_W'(k)] <= push_data[k];
    end
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes up to NCOMMIT retirements per cycle into one RVFI commit per cycle.
// clk, rst  : clock, async active-high reset
// in_valid  : per-lane retire valid, expected contiguous from lane 0 (lane 0 oldest)
// in_pkt    : per-lane retire packet
// in_ready  : room for a full NCOMMIT-wide push (combinational from occupancy)
// commit    : out_pkt/order carry a retirement this cycle
// order     : gap-free retirement index of the presented packet
// out_pkt   : presented packet
// halt      : sticky, set when a self-looping instruction retires
// err       : sticky, set on a non-contiguous or not-ready push
module rvfi_commit_serializer
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ORDER_W = 64,
  parameter bit          HALT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCOMMIT-1:0]       in_valid,
  input  rvfi_pkt_t [NCOMMIT-1:0]  in_pkt,
  output logic                     in_ready,
  output logic                     commit,
  output logic [ORDER_W-1:0]       order,
  output rvfi_pkt_t                out_pkt,
  output logic                     halt,
  output logic                     err
);

  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned PUSH_N_W = $clog2(NCOMMIT + 1);

  logic [LANE_CNT_W-1:0] lead_n_c;
  logic [NCOMMIT-1:0]    contig_mask_c;
  logic                  any_valid_c;
  logic                  noncontig_c;
  logic [PUSH_N_W-1:0]   push_n_c;
  logic                  pop_c;
  logic                  halt_hit_c;
  logic                  err_set_c;
  logic [PKT_W-1:0]      head_bits;
  rvfi_pkt_t             head_pkt_c;
  logic [CNT_W-1:0]      count;
  logic [ORDER_W-1:0]    ord_cnt;

  // Lane qualification: only the contiguous prefix of valid lanes is pushed.
  always_comb begin
    contig_mask_c = '0;
    lead_n_c      = popcount_contig(MAX_LANES'(in_valid));
    for (int k = 0; k < NCOMMIT; k++) begin
      contig_mask_c[k] = (LANE_CNT_W'(k) < lead_n_c);
    end
  end

  assign any_valid_c = |in_valid;
  assign noncontig_c = (in_valid != contig_mask_c);

  // Ignores this cycle's pop; halt freezes the buffer so it also blocks pushes.
  assign in_ready = !halt && ((CNT_W'(DEPTH) - count) >= CNT_W'(NCOMMIT));

  assign push_n_c   = (in_ready && any_valid_c) ? PUSH_N_W'(lead_n_c) : '0;
  assign pop_c      = (count != '0) && !halt;
  assign head_pkt_c = rvfi_pkt_t'(head_bits);
  assign halt_hit_c = HALT_EN && pop_c && !head_pkt_c.trap &&
                      (head_pkt_c.pc_wdata == head_pkt_c.pc_rdata);
  // Pushes attempted after halt are dropped silently.
  assign err_set_c  = any_valid_c && !halt && (noncontig_c || !in_ready);

  multi_push_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH),
    .NPUSH (NCOMMIT)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n    (push_n_c),
    .push_data (in_pkt),
    .pop       (pop_c),
    .head      (head_bits),
    .count     (count)
  );

  // Output stage, order counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit  <= 1'b0;
      order   <= '0;
      out_pkt <= '0;
      halt    <= 1'b0;
      err     <= 1'b0;
      ord_cnt <= '0;
    end else begin
      commit <= pop_c;
      if (pop_c) begin
        out_pkt <= head_pkt_c;
        order   <= ord_cnt;
        ord_cnt <= ord_cnt + ORDER_W'(1);
      end
      if (halt_hit_c) halt <= 1'b1;
      if (err_set_c)  err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed self-checking bench for rvfi_commit_serializer (NCOMMIT=2, DEPTH=8).
module tb_rvfi_commit_serializer;
  import rvfi_mon_pkg::*;

  localparam int unsigned NCOMMIT = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ORDER_W = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NCOMMIT-1:0]      in_valid;
  rvfi_pkt_t [NCOMMIT-1:0] in_pkt;
  logic                    in_ready;
  logic                    commit;
  logic [ORDER_W-1:0]      order;
  rvfi_pkt_t               out_pkt;
  logic                    halt;
  logic                    err;

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          n_commit = 0;
  int          mdl_cnt  = 0;
  int          c0;
  logic [63:0] exp_order = '0;
  logic [31:0] exp_q [$];

  rvfi_commit_serializer #(
    .NCOMMIT (NCOMMIT),
    .DEPTH   (DEPTH),
    .ORDER_W (ORDER_W),
    .HALT_EN (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_pkt   (in_pkt),
    .in_ready (in_ready),
    .commit   (commit),
    .order    (order),
    .out_pkt  (out_pkt),
    .halt     (halt),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic [31:0] pc, input logic [31:0] npc);
    in_pkt[lane]          = '0;
    in_pkt[lane].inst     = pc ^ 32'h0000_0013;
    in_pkt[lane].pc_rdata = pc;
    in_pkt[lane].pc_wdata = npc;
  endtask

  // Advance one clock and check any commit against the scoreboard.
  task automatic tick();
    logic [31:0] exp_pc;
    @(posedge clk);
    #1;
    if (commit === 1'b1) begin
      n_commit++;
      chk("commit_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        chk("commit_pc", 64'(out_pkt.pc_rdata), 64'(exp_pc));
        chk("commit_order", order, exp_order);
        exp_order = exp_order + 64'd1;
      end
    end
  endtask

  // Push npush full-width groups as fast as the buffer allows, then drain.
  // With inject set, one push is attempted while the buffer is not ready.
  task automatic stream(input int npush, input bit inject, input logic [31:0] base);
    int done = 0;
    bit inj = 1'b0;
    int guard = 0;
    int cnt_before;
    int pushed;
    logic [31:0] pc;
    while ((done < npush || mdl_cnt != 0 || (inject && !inj)) && guard < 200) begin
      pushed = 0;
      chk("stream_in_ready", 64'(in_ready), 64'(mdl_cnt <= int'(DEPTH - NCOMMIT)));
      if (done < npush && mdl_cnt <= int'(DEPTH - NCOMMIT)) begin
        pc = base + 32'(done * 8);
        set_lane(0, pc, pc + 32'd4);
        set_lane(1, pc + 32'd4, pc + 32'd8);
        in_valid = 2'b11;
        exp_q.push_back(pc);
        exp_q.push_back(pc + 32'd4);
        pushed = 2;
        done++;
      end else if (inject && !inj && mdl_cnt > int'(DEPTH - NCOMMIT)) begin
        set_lane(0, 32'hBAD0, 32'hBAD4);
        set_lane(1, 32'hBAD4, 32'hBAD8);
        in_valid = 2'b11;
        inj = 1'b1;
      end else begin
        in_valid = '0;
      end
      cnt_before = mdl_cnt;
      tick();
      in_valid = '0;
      chk("stream_throughput", 64'(commit), 64'(cnt_before != 0));
      mdl_cnt = cnt_before + pushed - ((cnt_before != 0) ? 1 : 0);
      guard++;
    end
    chk("stream_bounded", 64'(guard < 200), 64'd1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_pkt   = '0;
    #2;
    chk("rst_commit",   64'(commit),   64'd0);
    chk("rst_order",    order,         64'd0);
    chk("rst_halt",     64'(halt),     64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pkt",  64'(out_pkt.pc_rdata), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Two-lane push: lane 0 commits one cycle after the push, lane 1 one later.
    set_lane(0, 32'h60, 32'h64);
    set_lane(1, 32'h64, 32'h68);
    in_valid = 2'b11;
    exp_q.push_back(32'h60);
    exp_q.push_back(32'h64);
    tick();
    in_valid = '0;
    chk("pair_no_commit_at_push", 64'(commit), 64'd0);
    tick();
    chk("pair_commit_lane0", 64'(commit), 64'd1);
    tick();
    chk("pair_commit_lane1", 64'(commit), 64'd1);
    tick();
    chk("pair_idle", 64'(commit), 64'd0);

    // Back-to-back pushes: one commit per cycle, orders continue without gaps.
    c0 = n_commit;
    stream(8, 1'b0, 32'h1000);
    chk("stream_err_clear", 64'(err), 64'd0);
    chk("stream_commits", 64'(n_commit - c0), 64'd16);
    chk("stream_order_end", exp_order, 64'd18);

    // Self-loop in lane 1 halts; a later queued packet never commits.
    set_lane(0, 32'h70, 32'h74);
    set_lane(1, 32'h80, 32'h80);
    in_valid = 2'b11;
    exp_q.push_back(32'h70);
    exp_q.push_back(32'h80);
    tick();
    chk("halt_push_commit", 64'(commit), 64'd0);
    set_lane(0, 32'hA0, 32'hA4);
    in_valid = 2'b01;
    tick();
    in_valid = '0;
    chk("halt_lane0_commit", 64'(commit), 64'd1);
    chk("halt_lane0_halt",   64'(halt),   64'd0);
    tick();
    chk("halt_lane1_commit", 64'(commit), 64'd1);
    chk("halt_lane1_halt",   64'(halt),   64'd1);
    chk("halt_lane1_pc",     64'(out_pkt.pc_wdata), 64'h80);
    chk("halt_in_ready",     64'(in_ready), 64'd0);
    set_lane(0, 32'h90, 32'h94);
    set_lane(1, 32'h94, 32'h98);
    in_valid = 2'b11;
    tick();
    in_valid = '0;
    chk("halt_frozen_commit", 64'(commit), 64'd0);
    chk("halt_push_no_err",   64'(err),    64'd0);
    tick();
    chk("halt_frozen_commit2", 64'(commit), 64'd0);
    chk("halt_sticky",         64'(halt),   64'd1);

    // Asynchronous reset mid-cycle clears halt and order before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halt",     64'(halt),     64'd0);
    chk("arst_order",    order,         64'd0);
    chk("arst_commit",   64'(commit),   64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_order = '0;
    mdl_cnt   = 0;
    tick();
    chk("arst_lost_pkt", 64'(commit), 64'd0);

    // Non-contiguous valid: flagged, nothing pushed.
    set_lane(0, 32'h150, 32'h154);
    set_lane(1, 32'h154, 32'h158);
    in_valid = 2'b10;
    tick();
    in_valid = '0;
    chk("noncontig_err",    64'(err),    64'd1);
    chk("noncontig_commit", 64'(commit), 64'd0);
    tick();
    chk("noncontig_nothing_pushed", 64'(commit), 64'd0);
    chk("noncontig_in_ready", 64'(in_ready), 64'd1);

    // Reset while a commit is being presented and err is set.
    set_lane(0, 32'h200, 32'h204);
    set_lane(1, 32'h204, 32'h208);
    in_valid = 2'b11;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    tick();
    in_valid = '0;
    tick();
    chk("mid_commit_before_rst", 64'(commit), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_commit", 64'(commit), 64'd0);
    chk("mid_rst_err",    64'(err),    64'd0);
    chk("mid_rst_order",  order,       64'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_order = '0;
    mdl_cnt   = 0;
    tick();
    chk("mid_rst_lost_pkt", 64'(commit), 64'd0);

    // Push while not ready: dropped, flagged, order sequence unaffected.
    c0 = n_commit;
    stream(8, 1'b1, 32'h3000);
    chk("notready_err",      64'(err), 64'd1);
    chk("notready_commits",  64'(n_commit - c0), 64'd16);
    chk("notready_order_end", exp_order, 64'd16);
    chk("notready_in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
